// File: rtl/datapath_core.sv
// Single-bus datapath: GPRs, HI/LO, PC, IR, MAR, MDR, Y, 64-bit Z, ALU; bus is combinational, loads land on the next rising clk, no backpressure.
// Define DATAPATH_MULDIV_EN to build the signed multiplier/divider for opcodes 2/3; without it they yield Z = 0.
module datapath_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      enable,
    input  logic [31:0]      busSelect,
    input  logic [WIDTH-1:0] inPort,
    input  logic [WIDTH-1:0] MDataIn,
    input  logic             MD_Read,
    input  logic [3:0]       Control_Signals,
    output logic [WIDTH-1:0] busMuxOut
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int NGPR  = 16;
    localparam int NSRC  = 23;

    localparam int EN_HI  = 16;
    localparam int EN_LO  = 17;
    localparam int EN_PC  = 20;
    localparam int EN_MDR = 21;
    localparam int EN_IR  = 23;
    localparam int EN_Z   = 24;
    localparam int EN_MAR = 25;
    localparam int EN_INC = 26;
    localparam int EN_Y   = 27;

    localparam int SEL_HI  = 16;
    localparam int SEL_LO  = 17;
    localparam int SEL_ZH  = 18;
    localparam int SEL_ZL  = 19;
    localparam int SEL_PC  = 20;
    localparam int SEL_MDR = 21;
    localparam int SEL_IN  = 22;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_SHR  = 4'd6,
        OP_SHRA = 4'd7,
        OP_SHL  = 4'd8,
        OP_ROR  = 4'd9,
        OP_ROL  = 4'd10,
        OP_NEG  = 4'd11,
        OP_NOT  = 4'd12
    } alu_op_e;

    logic [WIDTH-1:0]   r_q [NGPR];
    logic [WIDTH-1:0]   r_d [NGPR];
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   ir_q, ir_d;
    logic [WIDTH-1:0]   mar_q, mar_d;
    logic [WIDTH-1:0]   mdr_q, mdr_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [2*WIDTH-1:0] z_q, z_d;

    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   bus_src [NSRC];

    // ---------------------------------------------------------------
    // Bus multiplexer: scanning from the top down lets the lowest
    // asserted select bit overwrite any higher one.
    // ---------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NGPR; i++) begin
            bus_src[i] = r_q[i];
        end
        bus_src[SEL_HI]  = hi_q;
        bus_src[SEL_LO]  = lo_q;
        bus_src[SEL_ZH]  = z_q[2*WIDTH-1:WIDTH];
        bus_src[SEL_ZL]  = z_q[WIDTH-1:0];
        bus_src[SEL_PC]  = pc_q;
        bus_src[SEL_MDR] = mdr_q;
        bus_src[SEL_IN]  = inPort;

        bus = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (busSelect[i]) begin
                bus = bus_src[i];
            end
        end
    end

    assign busMuxOut = bus;

    // ---------------------------------------------------------------
    // ALU: A = Y, B = bus
    // ---------------------------------------------------------------
    alu_op_e            alu_op;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   rot_r;
    logic [WIDTH-1:0]   rot_l;
    logic [2*WIDTH-1:0] mul_res;
    logic [2*WIDTH-1:0] div_res;
    logic [2*WIDTH-1:0] alu_res;

    assign alu_op = alu_op_e'(Control_Signals);
    assign alu_a  = y_q;
    assign alu_b  = bus;
    assign shamt  = alu_b[SHW-1:0];

    // Rotating the doubled word makes an amount of zero return A for free.
    assign rot_r = WIDTH'({alu_a, alu_a} >> shamt);
    assign rot_l = WIDTH'(({alu_a, alu_a} << shamt) >> WIDTH);

`ifdef DATAPATH_MULDIV_EN
    logic signed [2*WIDTH-1:0] mul_full;
    logic signed [WIDTH-1:0]   div_q;
    logic signed [WIDTH-1:0]   div_r;
    logic                      div_by_zero;

    always_comb begin
        mul_full    = $signed({{WIDTH{alu_a[WIDTH-1]}}, alu_a})
                    * $signed({{WIDTH{alu_b[WIDTH-1]}}, alu_b});
        div_by_zero = (alu_b == '0);
        div_q       = '0;
        div_r       = '0;
        if (!div_by_zero) begin
            div_q = $signed(alu_a) / $signed(alu_b);
            div_r = $signed(alu_a) % $signed(alu_b);
        end
    end

    assign mul_res = mul_full;
    assign div_res = div_by_zero ? {alu_a, {WIDTH{1'b0}}} : {div_r, div_q};
`else
    assign mul_res = '0;
    assign div_res = '0;
`endif

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res[WIDTH-1:0] = alu_a + alu_b;
            OP_SUB:  alu_res[WIDTH-1:0] = alu_a - alu_b;
            OP_MUL:  alu_res            = mul_res;
            OP_DIV:  alu_res            = div_res;
            OP_AND:  alu_res[WIDTH-1:0] = alu_a & alu_b;
            OP_OR:   alu_res[WIDTH-1:0] = alu_a | alu_b;
            OP_SHR:  alu_res[WIDTH-1:0] = alu_a >> shamt;
            OP_SHRA: alu_res[WIDTH-1:0] = $signed(alu_a) >>> shamt;
            OP_SHL:  alu_res[WIDTH-1:0] = alu_a << shamt;
            OP_ROR:  alu_res[WIDTH-1:0] = rot_r;
            OP_ROL:  alu_res[WIDTH-1:0] = rot_l;
            OP_NEG:  alu_res[WIDTH-1:0] = {WIDTH{1'b0}} - alu_b;
            OP_NOT:  alu_res[WIDTH-1:0] = ~alu_b;
            default: alu_res[WIDTH-1:0] = alu_b;
        endcase
    end

    // ---------------------------------------------------------------
    // Register next-state
    // ---------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NGPR; i++) begin
            r_d[i] = enable[i] ? bus : r_q[i];
        end
        hi_d  = enable[EN_HI]  ? bus : hi_q;
        lo_d  = enable[EN_LO]  ? bus : lo_q;
        ir_d  = enable[EN_IR]  ? bus : ir_q;
        mar_d = enable[EN_MAR] ? bus : mar_q;
        y_d   = enable[EN_Y]   ? bus : y_q;
        mdr_d = enable[EN_MDR] ? (MD_Read ? MDataIn : bus) : mdr_q;
        z_d   = enable[EN_Z]   ? alu_res : z_q;

        // Increment wins over a bus load when both are requested.
        if (enable[EN_INC]) begin
            pc_d = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (enable[EN_PC]) begin
            pc_d = bus;
        end else begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NGPR; i++) begin
                r_q[i] <= '0;
            end
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < NGPR; i++) begin
                r_q[i] <= r_d[i];
            end
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

    // IR and MAR feed logic outside this block; reserved map bits are don't-cares.
    logic unused_bits;
    assign unused_bits = ^{enable[31:28], enable[22], enable[19:18],
                           busSelect[31:23], ir_q, mar_q};

endmodule

// File: tb/tb_datapath_core.sv
// Directed-vector bench for datapath_core; expectations follow DATAPATH_MULDIV_EN when defined.
module tb_datapath_core;

    localparam logic [31:0] B_HI  = 32'h0001_0000;
    localparam logic [31:0] B_LO  = 32'h0002_0000;
    localparam logic [31:0] B_ZH  = 32'h0004_0000;
    localparam logic [31:0] B_ZL  = 32'h0008_0000;
    localparam logic [31:0] B_PC  = 32'h0010_0000;
    localparam logic [31:0] B_MDR = 32'h0020_0000;
    localparam logic [31:0] B_IN  = 32'h0040_0000;
    localparam logic [31:0] B_IR  = 32'h0080_0000;
    localparam logic [31:0] B_Z   = 32'h0100_0000;
    localparam logic [31:0] B_MAR = 32'h0200_0000;
    localparam logic [31:0] B_INC = 32'h0400_0000;
    localparam logic [31:0] B_Y   = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic [31:0] inPort;
    logic [31:0] MDataIn;
    logic        MD_Read;
    logic [3:0]  Control_Signals;
    logic [31:0] busMuxOut;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    datapath_core #(.WIDTH(32)) dut (
        .clk             (clk),
        .clr             (clr),
        .enable          (enable),
        .busSelect       (busSelect),
        .inPort          (inPort),
        .MDataIn         (MDataIn),
        .MD_Read         (MD_Read),
        .Control_Signals (Control_Signals),
        .busMuxOut       (busMuxOut)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rb(input int n);
        return 32'h1 << n;
    endfunction

    task automatic step(input logic [31:0] en, input logic [31:0] sel);
        enable    = en;
        busSelect = sel;
        @(posedge clk);
        #1;
        enable    = '0;
        busSelect = '0;
    endtask

    task automatic load_in(input logic [31:0] en, input logic [31:0] v);
        inPort = v;
        step(en, B_IN);
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        load_in(B_Y, a);
        Control_Signals = op;
        load_in(B_Z, b);
    endtask

    logic [31:0] mul_hi, mul_lo, div_hi, div_lo, dz_hi;

    initial begin
`ifdef DATAPATH_MULDIV_EN
        mul_hi = 32'hFFFF_FFFF; mul_lo = 32'hFFFF_FFEB;
        div_hi = 32'd2;         div_lo = 32'd3;
        dz_hi  = 32'd17;
`else
        mul_hi = '0; mul_lo = '0;
        div_hi = '0; div_lo = '0;
        dz_hi  = '0;
`endif
        clr = 1'b1; enable = '0; busSelect = '0; inPort = '0;
        MDataIn = '0; MD_Read = 1'b0; Control_Signals = '0;

        // Reset state
        @(posedge clk); #1;
        busSelect = B_MDR | rb(0); #1;
        check("rst_bus_zero", busMuxOut, 0);
        busSelect = B_IN; inPort = 32'hCAFE_0001; #1;
        check("rst_bus_inport", busMuxOut, 32'hCAFE_0001);
        busSelect = '0;
        check("rst_pc", dut.pc_q, 0);
        check("rst_z", dut.z_q, 0);
        @(posedge clk); #1;
        clr = 1'b0;

        // MDR from memory, then MDR -> R3
        MD_Read = 1'b1; MDataIn = 32'h0000_0001;
        step(B_MDR, '0);
        MD_Read = 1'b0;
        enable = rb(3); busSelect = B_MDR; #1;
        check("mdr_drive_bus", busMuxOut, 32'h1);
        step(rb(3), B_MDR);
        check("r3_from_mdr", dut.r_q[3], 32'h1);

        // ROR via registers: Y=R3=1, B=R5=4
        load_in(rb(5), 32'd4);
        step(B_Y, rb(3));
        Control_Signals = 4'd9;
        step(B_Z, rb(5));
        step(rb(1), B_ZL);
        check("ror_r1", dut.r_q[1], 32'h1000_0000);
        check("ror_zhi", dut.z_q[63:32], 0);

        alu(4'd10, 32'h1, 32'd4);           check("rol", dut.z_q, 64'h10);
        alu(4'd9,  32'h1, 32'h20);          check("ror_amt0", dut.z_q, 64'h1);
        alu(4'd0,  32'h1, 32'hFFFF_FFFF);   check("add_wrap", dut.z_q, 64'h0);
        alu(4'd1,  32'h1, 32'h2);           check("sub_wrap", dut.z_q, 64'hFFFF_FFFF);
        alu(4'd4,  32'hFF00_FF00, 32'h0FF0_0FF0); check("and", dut.z_q, 64'h0F00_0F00);
        alu(4'd5,  32'hFF00_FF00, 32'h0FF0_0FF0); check("or", dut.z_q, 64'hFFF0_FFF0);
        alu(4'd6,  32'h8000_0000, 32'd4);   check("shr", dut.z_q, 64'h0800_0000);
        alu(4'd7,  32'h8000_0000, 32'd4);   check("shra", dut.z_q, 64'hF800_0000);
        alu(4'd8,  32'h0000_000F, 32'd4);   check("shl", dut.z_q, 64'hF0);
        alu(4'd11, 32'h5, 32'h1);           check("neg", dut.z_q, 64'hFFFF_FFFF);
        alu(4'd12, 32'h5, 32'h0F0F_0F0F);   check("not", dut.z_q, 64'hF0F0_F0F0);
        alu(4'd14, 32'h5, 32'h1234_5678);   check("op14_passb", dut.z_q, 64'h1234_5678);

        // MUL / DIV
        alu(4'd2, 32'hFFFF_FFFD, 32'd7);    check("mul", dut.z_q, {mul_hi, mul_lo});
        alu(4'd3, 32'd17, 32'd5);           check("div", dut.z_q, {div_hi, div_lo});
        busSelect = B_ZH; #1;
        check("div_zhi_bus", busMuxOut, div_hi);
        busSelect = '0;
        alu(4'd3, 32'd17, 32'd0);           check("div_by_zero", dut.z_q, {dz_hi, 32'h0});

        // PC / IncPC
        step(B_MAR | B_INC, B_PC);
        check("mar_from_pc", dut.mar_q, 0);
        check("pc_inc", dut.pc_q, 1);
        load_in(B_PC, 32'hFFFF_FFFF);
        check("pc_load", dut.pc_q, 32'hFFFF_FFFF);
        step(B_INC | B_PC, '0);
        check("pc_inc_wrap", dut.pc_q, 0);

        // Bus priority
        MD_Read = 1'b1; MDataIn = 32'h0000_ABCD;
        step(B_MDR, '0);
        MD_Read = 1'b0;
        busSelect = rb(3) | B_MDR; #1;
        check("prio_r3_mdr", busMuxOut, 32'h1);
        busSelect = B_MDR | B_IN; #1;
        check("prio_mdr_in", busMuxOut, 32'h0000_ABCD);
        busSelect = 32'h8000_0000; #1;
        check("prio_invalid", busMuxOut, 0);
        busSelect = '0; #1;
        check("prio_none", busMuxOut, 0);
        load_in(B_HI, 32'hDEAD_0001);
        load_in(B_LO, 32'hBEEF_0002);
        busSelect = B_HI | B_LO; #1;
        check("prio_hi_lo", busMuxOut, 32'hDEAD_0001);
        busSelect = B_LO; #1;
        check("lo_drive", busMuxOut, 32'hBEEF_0002);
        busSelect = '0;

        // Same-edge drive and load of MDR
        MD_Read = 1'b1; MDataIn = 32'h0000_0077;
        step(B_MDR | rb(2), B_MDR);
        MD_Read = 1'b0;
        check("r2_old_mdr", dut.r_q[2], 32'h0000_ABCD);
        check("mdr_new", dut.mdr_q, 32'h0000_0077);

        load_in(B_IR, 32'h1357_9BDF);
        check("ir_load", dut.ir_q, 32'h1357_9BDF);
        load_in(B_MAR | B_PC, 32'h0000_0123);
        check("mar_load", dut.mar_q, 32'h123);

        // Asynchronous reset mid-cycle with R1 load held
        #2;
        enable = rb(1); busSelect = B_IN; inPort = 32'h55;
        clr = 1'b1; #1;
        check("clr_r1", dut.r_q[1], 0);
        check("clr_r3", dut.r_q[3], 0);
        check("clr_pc", dut.pc_q, 0);
        check("clr_mar", dut.mar_q, 0);
        check("clr_ir", dut.ir_q, 0);
        check("clr_mdr", dut.mdr_q, 0);
        check("clr_y", dut.y_q, 0);
        check("clr_hi", dut.hi_q, 0);
        check("clr_z", dut.z_q, 0);
        check("clr_bus_inport", busMuxOut, 32'h55);
        @(posedge clk); #1;
        check("clr_r1_held", dut.r_q[1], 0);
        clr = 1'b0;
        step(rb(1), B_IN);
        check("post_clr_r1", dut.r_q[1], 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
